// File: rtl/led_pwm_pkg.sv
// rtl/led_pwm_pkg.sv - shared types for the LED PWM driver
`include "led_pwm_defines.v"

package led_pwm_pkg;

    localparam int LED_WIDTH = `LED_PWM_LED_WIDTH;

    typedef logic [LED_WIDTH-1:0] led_t;

endpackage

// File: rtl/led_pwm_defines.v
// rtl/led_pwm_defines.v - shared defaults and constants for the LED PWM driver
`ifndef LED_PWM_DEFINES_V
`define LED_PWM_DEFINES_V

`define LED_PWM_PRESCALE_DFLT       48
`define LED_PWM_PWM_BITS_DFLT       4
`define LED_PWM_STRETCH_FRAMES_DFLT 8
`define LED_PWM_LED_WIDTH           8
`define LED_PWM_DUTY_FULL(bits)     ({(bits){1'b1}})

`endif

// File: rtl/led_pwm_prescaler.sv
// rtl/led_pwm_prescaler.sv - enable-gated modulo-PRESCALE counter producing a step tick
`include "led_pwm_defines.v"

module led_pwm_prescaler #(
    parameter int PRESCALE = `LED_PWM_PRESCALE_DFLT
) (
    input  logic clk,
    input  logic reset,
    input  logic enable_i,
    output logic tick_o
);

    localparam int CNT_W = $clog2(PRESCALE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] pre_cnt_q;
    logic [CNT_W-1:0] pre_cnt_d;

    always_comb begin
        pre_cnt_d = pre_cnt_q;
        if (enable_i) begin
            pre_cnt_d = (pre_cnt_q == CNT_LAST) ? '0 : pre_cnt_q + 1'b1;
        end
    end

    assign tick_o = enable_i && (pre_cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end

endmodule

// File: rtl/led_pwm_driver.sv
// rtl/led_pwm_driver.sv - registered 8-bit LED output with frame-synchronous PWM brightness
// Optional per-LED on-stretch after a rising edge: define LED_PWM_STRETCH_EN.
`include "led_pwm_defines.v"

module led_pwm_driver
    import led_pwm_pkg::*;
#(
    parameter int PRESCALE = `LED_PWM_PRESCALE_DFLT,
    parameter int PWM_BITS = `LED_PWM_PWM_BITS_DFLT
`ifdef LED_PWM_STRETCH_EN
    ,
    parameter int STRETCH_FRAMES = `LED_PWM_STRETCH_FRAMES_DFLT
`endif
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable_i,
    input  logic [7:0]          led_i,
    input  logic [PWM_BITS-1:0] duty_i,
    input  logic                duty_we_i,
    output logic [7:0]          led_o,
    output logic                frame_o
);

    localparam logic [PWM_BITS-1:0] DUTY_FULL = `LED_PWM_DUTY_FULL(PWM_BITS);

    led_t                led_q_q, led_q_d;
    led_t                led_o_q, led_o_d;
    logic                frame_q, frame_d;
    logic [PWM_BITS-1:0] step_cnt_q, step_cnt_d;
    logic [PWM_BITS-1:0] duty_pend_q, duty_pend_d;
    logic [PWM_BITS-1:0] duty_act_q, duty_act_d;
    logic                tick;
    logic                wrap;
    logic                pwm_on;
    led_t                str_hold;

    led_pwm_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .enable_i (enable_i),
        .tick_o   (tick)
    );

    assign wrap   = tick && (step_cnt_q == DUTY_FULL);
    // Full scale bypasses the compare so 100% never dips on the last step.
    assign pwm_on = (duty_act_q == DUTY_FULL) || (step_cnt_q < duty_act_q);

    always_comb begin
        led_q_d     = led_i;
        step_cnt_d  = step_cnt_q;
        duty_pend_d = duty_we_i ? duty_i : duty_pend_q;
        duty_act_d  = duty_act_q;
        frame_d     = wrap;
        if (tick) begin
            step_cnt_d = wrap ? '0 : step_cnt_q + 1'b1;
        end
        if (wrap) begin
            duty_act_d = duty_pend_d;
        end
        led_o_d = enable_i ? (led_q_q & ({LED_WIDTH{pwm_on}} | str_hold)) : '0;
    end

`ifdef LED_PWM_STRETCH_EN
    localparam int STR_W = $clog2(STRETCH_FRAMES + 1);
    localparam logic [STR_W-1:0] STR_LOAD = STR_W'(STRETCH_FRAMES);

    logic [STR_W-1:0] str_cnt_q [LED_WIDTH];
    logic [STR_W-1:0] str_cnt_d [LED_WIDTH];

    always_comb begin
        for (int i = 0; i < LED_WIDTH; i++) begin
            str_cnt_d[i] = str_cnt_q[i];
            if (led_i[i] && !led_q_q[i]) begin
                str_cnt_d[i] = STR_LOAD;
            end else if (!led_i[i]) begin
                str_cnt_d[i] = '0;
            end else if (wrap && (str_cnt_q[i] != '0)) begin
                str_cnt_d[i] = str_cnt_q[i] - 1'b1;
            end
            str_hold[i] = (str_cnt_q[i] != '0);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LED_WIDTH; i++) begin
            if (reset) begin
                str_cnt_q[i] <= '0;
            end else begin
                str_cnt_q[i] <= str_cnt_d[i];
            end
        end
    end
`else
    assign str_hold = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            led_q_q     <= '0;
            led_o_q     <= '0;
            frame_q     <= 1'b0;
            step_cnt_q  <= '0;
            duty_pend_q <= DUTY_FULL;
            duty_act_q  <= DUTY_FULL;
        end else begin
            led_q_q     <= led_q_d;
            led_o_q     <= led_o_d;
            frame_q     <= frame_d;
            step_cnt_q  <= step_cnt_d;
            duty_pend_q <= duty_pend_d;
            duty_act_q  <= duty_act_d;
        end
    end

    assign led_o   = led_o_q;
    assign frame_o = frame_q;

endmodule

// File: tb/tb_led_pwm_driver.sv
// tb/tb_led_pwm_driver.sv - scoreboard bench for led_pwm_driver against a cycle-count reference model
`timescale 1ns/1ps

module tb_led_pwm_driver;

    localparam int P     = 4;
    localparam int STEPS = 16;
    localparam int FRAME = P * STEPS;
    localparam int FULL  = STEPS - 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable_i;
    logic [7:0] led_i;
    logic [3:0] duty_i;
    logic       duty_we_i;
    logic [7:0] led_o;
    logic       frame_o;

    always #5 clk = ~clk;

    led_pwm_driver #(
        .PRESCALE (P),
        .PWM_BITS (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable_i  (enable_i),
        .led_i     (led_i),
        .duty_i    (duty_i),
        .duty_we_i (duty_we_i),
        .led_o     (led_o),
        .frame_o   (frame_o)
    );

    typedef struct packed {
        logic [7:0] led;
        logic       frame;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model: position in the frame derives from the count of enabled cycles.
    int         n_en;
    int         pend;
    int         act;
    logic [7:0] lq;
    int         sc[8];

    function automatic bit next_is_wrap();
        return (n_en % FRAME) == FRAME - 1;
    endfunction

    function automatic int cur_step();
        return (n_en / P) % STEPS;
    endfunction

    task automatic drive(input logic rst, input logic en, input logic [7:0] led,
                         input logic [3:0] d, input logic we);
        exp_t e;
        bit   wrapnow;
        bit   on;
        reset     = rst;
        enable_i  = en;
        led_i     = led;
        duty_i    = d;
        duty_we_i = we;
        e = '0;
        if (rst) begin
            n_en = 0;
            pend = FULL;
            act  = FULL;
            lq   = '0;
            for (int i = 0; i < 8; i++) sc[i] = 0;
        end else begin
            wrapnow = en && next_is_wrap();
            on      = (act == FULL) || (cur_step() < act);
            if (en) begin
                for (int i = 0; i < 8; i++) e.led[i] = lq[i] && (on || sc[i] > 0);
            end
            e.frame = wrapnow;
`ifdef LED_PWM_STRETCH_EN
            for (int i = 0; i < 8; i++) begin
                if (led[i] && !lq[i])         sc[i] = 8;
                else if (!led[i])             sc[i] = 0;
                else if (wrapnow && sc[i] > 0) sc[i] = sc[i] - 1;
            end
`endif
            if (we) pend = int'(d);
            if (wrapnow) act = pend;
            lq = led;
            if (en) n_en++;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (led_o !== e.led) begin
                    errors++;
                    $display("FAIL led_o cycle %0d got %h expected %h", cyc, led_o, e.led);
                end
                checks++;
                if (frame_o !== e.frame) begin
                    errors++;
                    $display("FAIL frame_o cycle %0d got %b expected %b", cyc, frame_o, e.frame);
                end
            end
        end
    end

    initial begin : stimulus
        bit         en_r;
        logic [7:0] led_r;
        logic [3:0] d_r;
        reset = 1'b1; enable_i = 1'b0; led_i = '0; duty_i = '0; duty_we_i = 1'b0;

        repeat (3) drive(1, 0, 8'h00, 4'd0, 0);
        repeat (140) drive(0, 1, 8'hA5, 4'd0, 0);

        repeat (10) drive(0, 1, 8'hA5, 4'd0, 0);
        drive(0, 1, 8'hA5, 4'd4, 1);
        repeat (200) drive(0, 1, 8'hA5, 4'd0, 0);

        while (!next_is_wrap()) drive(0, 1, 8'hA5, 4'd0, 0);
        drive(0, 1, 8'hA5, 4'd0, 1);
        repeat (140) drive(0, 1, 8'hA5, 4'd0, 0);

        drive(0, 1, 8'h3C, 4'd9, 1);
        repeat (100) drive(0, 1, 8'h3C, 4'd0, 0);
        repeat (20) drive(0, 0, 8'h3C, 4'd0, 0);
        repeat (100) drive(0, 1, 8'h3C, 4'd0, 0);

        drive(0, 1, 8'hA5, 4'd4, 1);
        while (!next_is_wrap()) drive(0, 1, 8'hA5, 4'd0, 0);
        drive(0, 1, 8'hA5, 4'd0, 0);
        while (cur_step() != 7) drive(0, 1, 8'hA5, 4'd0, 0);
        drive(1, 1, 8'hA5, 4'd0, 0);
        repeat (80) drive(0, 1, 8'hA5, 4'd0, 0);

`ifdef LED_PWM_STRETCH_EN
        drive(0, 1, 8'h00, 4'd0, 1);
        repeat (70) drive(0, 1, 8'h00, 4'd0, 0);
        repeat (600) drive(0, 1, 8'h01, 4'd0, 0);
        repeat (10) drive(0, 1, 8'h00, 4'd0, 0);
        repeat (150) drive(0, 1, 8'h01, 4'd0, 0);
        repeat (10) drive(0, 1, 8'h00, 4'd0, 0);
`endif

        en_r  = 1'b1;
        led_r = 8'h5A;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 99) < 2)  en_r  = ~en_r;
            if ($urandom_range(0, 99) < 10) led_r = 8'($urandom());
            d_r = 4'($urandom());
            drive(($urandom_range(0, 599) == 0), en_r, led_r, d_r,
                  ($urandom_range(0, 99) < 4));
        end

        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d entries expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
